// File: rtl/f_ifu_pkg.sv
// Shared constants, types and helpers for the fetch unit.
package f_ifu_pkg;

  // Default fetch window and reset PC (legacy Define.v values).
  localparam logic [31:0] F_PC_INIT_DEF = 32'h0000_3000;
  localparam logic [31:0] F_PC_MIN_DEF  = 32'h0000_3000;
  localparam logic [31:0] F_PC_MAX_DEF  = 32'h0000_6FFC;

  localparam logic [31:0] F_PC_STEP = 32'd4;
  localparam logic [31:0] F_NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_HOLD     = 2'd0,
    NPC_SEQ      = 2'd1,
    NPC_REDIRECT = 2'd2
  } npc_sel_e;

  // A fetch address is illegal when misaligned or outside [pc_min, pc_max].
  function automatic logic pc_is_illegal(input logic [31:0] pc,
                                         input logic [31:0] pc_min,
                                         input logic [31:0] pc_max);
    return (pc[1:0] != 2'b00) || (pc < pc_min) || (pc > pc_max);
  endfunction

endpackage

// File: rtl/f_ifu_if.sv
// Fetch-stage signal bundle: pipeline control in, imem access, IF/ID outputs.
interface f_ifu_if;
  logic        F_WE;
  logic        D_Redirect;
  logic [31:0] D_Target;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_ExcAdEL;
  logic        F_Redirected;

  // Fetch unit side.
  modport master (
    input  F_WE, D_Redirect, D_Target, i_inst_rdata,
    output i_inst_addr, F_PC, F_Instr, F_ExcAdEL, F_Redirected
  );

  // Pipeline / memory side.
  modport slave (
    output F_WE, D_Redirect, D_Target, i_inst_rdata,
    input  i_inst_addr, F_PC, F_Instr, F_ExcAdEL, F_Redirected
  );
endinterface

// File: rtl/f_pc_reg.sv
// 32-bit program counter register with reset value and write enable.
module f_pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] pc_nxt,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Load the new value only when enabled, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (we) pc_d = pc_nxt;
  end

  // PC storage; reset overrides the enable.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VAL;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/f_ifu.sv
// Fetch unit: PC sequencing with D-stage redirects (delay slot kept),
// stall hold, and fetch address error flagging.
module f_ifu
  import f_ifu_pkg::*;
#(
  parameter logic [31:0] PC_INIT = F_PC_INIT_DEF,
  parameter logic [31:0] PC_MIN  = F_PC_MIN_DEF,
  parameter logic [31:0] PC_MAX  = F_PC_MAX_DEF
) (
  input logic     clk,
  input logic     reset,
  f_ifu_if.master bus
);

  npc_sel_e    npc_sel;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirected_d;
  logic        redirected_q;
  logic        exc_adel;

  // A stalled fetch ignores the redirect; D presents it again next cycle.
  always_comb begin
    npc_sel = NPC_HOLD;
    if (bus.F_WE) npc_sel = bus.D_Redirect ? NPC_REDIRECT : NPC_SEQ;
  end

  // Next-PC mux; sequential increment wraps naturally at 2^32.
  always_comb begin
    pc_next = pc;
    case (npc_sel)
      NPC_SEQ:      pc_next = pc + F_PC_STEP;
      NPC_REDIRECT: pc_next = bus.D_Target;
      default:      pc_next = pc;
    endcase
  end

  f_pc_reg #(
    .RESET_VAL (PC_INIT)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.F_WE),
    .pc_nxt (pc_next),
    .pc     (pc)
  );

  // Redirect flag follows the applied redirect and holds during stalls.
  always_comb begin
    redirected_d = redirected_q;
    if (bus.F_WE) redirected_d = bus.D_Redirect;
  end

  // Redirect flag register.
  always_ff @(posedge clk) begin
    if (reset) redirected_q <= 1'b0;
    else       redirected_q <= redirected_d;
  end

  // Exception check and output drive, all from registered state only.
  always_comb begin
    exc_adel         = pc_is_illegal(pc, PC_MIN, PC_MAX);
    bus.i_inst_addr  = pc;
    bus.F_PC         = pc;
    bus.F_ExcAdEL    = exc_adel;
    bus.F_Instr      = exc_adel ? F_NOP : bus.i_inst_rdata;
    bus.F_Redirected = redirected_q;
  end

endmodule
